// File: rtl/d_branch_hazard_ctrl.sv
// d_branch_hazard_ctrl
// Controls the D-stage branch comparator. It tracks the destination register
// and remaining result latency (Tnew) of the instructions in E, M and W, stalls
// D when a branch/jr operand is still being produced, picks a forwarding source
// for each operand, and gates the comparator result into the NPC redirect.
// Optional build macro: BRANCH_STATS_EN adds stall-cycle and taken-branch counters.
module d_branch_hazard_ctrl #(
    parameter int TNEW_W = 2,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              D_valid,
    input  logic [NREG_W-1:0] D_rs,
    input  logic [NREG_W-1:0] D_rt,
    input  logic              D_is_branch,
    input  logic              D_is_jr,
    input  logic [NREG_W-1:0] D_wa,
    input  logic [TNEW_W-1:0] D_tnew,
    input  logic              cmp_eq,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              redirect,
    output logic [NREG_W-1:0] E_wa_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_stall_cycles,
    output logic [31:0]       stat_taken
`endif
);

    logic [NREG_W-1:0] E_wa_q, E_wa_d;
    logic [TNEW_W-1:0] E_tnew_q, E_tnew_d;
    logic [NREG_W-1:0] M_wa_q, M_wa_d;
    logic [TNEW_W-1:0] M_tnew_q, M_tnew_d;
    logic [NREG_W-1:0] W_wa_q, W_wa_d;
    logic              rs_used, rt_used;

    // An operand is blocked when a producer in this stage writes it and its
    // result is still more than zero cycles away. Register 0 never blocks.
    function automatic logic hazard(input logic              used,
                                    input logic [NREG_W-1:0] r,
                                    input logic [NREG_W-1:0] x_wa,
                                    input logic [TNEW_W-1:0] x_tnew);
        return used && (x_wa != '0) && (x_wa == r) && (x_tnew != '0);
    endfunction

    // Youngest producer whose result is already available wins; W is always ready.
    function automatic logic [1:0] pick_src(input logic [NREG_W-1:0] r,
                                            input logic [NREG_W-1:0] e_wa,
                                            input logic [TNEW_W-1:0] e_tnew,
                                            input logic [NREG_W-1:0] m_wa,
                                            input logic [TNEW_W-1:0] m_tnew,
                                            input logic [NREG_W-1:0] w_wa);
        logic [1:0] sel;
        sel = 2'd0;
        if (r != '0) begin
            if ((e_wa == r) && (e_tnew == '0))      sel = 2'd1;
            else if ((m_wa == r) && (m_tnew == '0)) sel = 2'd2;
            else if (w_wa == r)                     sel = 2'd3;
        end
        return sel;
    endfunction

    // Operand usage, stall, forward selects and redirect from the current scoreboard
    always_comb begin
        rs_used    = D_valid && (D_is_branch || D_is_jr);
        rt_used    = D_valid && D_is_branch;
        stall      = hazard(rs_used, D_rs, E_wa_q, E_tnew_q) ||
                     hazard(rs_used, D_rs, M_wa_q, M_tnew_q) ||
                     hazard(rt_used, D_rt, E_wa_q, E_tnew_q) ||
                     hazard(rt_used, D_rt, M_wa_q, M_tnew_q);
        fwd_rs_sel = pick_src(D_rs, E_wa_q, E_tnew_q, M_wa_q, M_tnew_q, W_wa_q);
        fwd_rt_sel = pick_src(D_rt, E_wa_q, E_tnew_q, M_wa_q, M_tnew_q, W_wa_q);
        redirect   = D_valid && D_is_branch && cmp_eq && !stall;
        E_wa_o     = E_wa_q;
    end

    // Scoreboard advance: entries shift E->M->W, Tnew counts down, D enters E unless bubbled
    always_comb begin
        W_wa_d   = M_wa_q;
        M_wa_d   = E_wa_q;
        M_tnew_d = (E_tnew_q == '0) ? '0 : E_tnew_q - TNEW_W'(1);
        if (stall || !D_valid) begin
            E_wa_d   = '0;
            E_tnew_d = '0;
        end else begin
            E_wa_d   = D_wa;
            E_tnew_d = D_tnew;
        end
    end

    // Scoreboard registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            E_wa_q   <= '0;
            E_tnew_q <= '0;
            M_wa_q   <= '0;
            M_tnew_q <= '0;
            W_wa_q   <= '0;
        end else begin
            E_wa_q   <= E_wa_d;
            E_tnew_q <= E_tnew_d;
            M_wa_q   <= M_wa_d;
            M_tnew_q <= M_tnew_d;
            W_wa_q   <= W_wa_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stall_cnt_q, taken_cnt_q;

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall};
            taken_cnt_q <= taken_cnt_q + {31'd0, redirect};
        end
    end

    assign stat_stall_cycles = stall_cnt_q;
    assign stat_taken        = taken_cnt_q;
`endif

endmodule

// File: tb/tb_d_branch_hazard_ctrl.sv
// Bench for d_branch_hazard_ctrl: directed pipeline scenarios plus random
// traffic, checked through an expectation queue against a history-based model.
module tb_d_branch_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       D_valid;
    logic [4:0] D_rs, D_rt, D_wa;
    logic       D_is_branch, D_is_jr;
    logic [1:0] D_tnew;
    logic       cmp_eq;
    logic       stall, redirect;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic [4:0] E_wa_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_stall_cycles, stat_taken;
`endif

    always #5 clk = ~clk;

    d_branch_hazard_ctrl #(.TNEW_W(2), .NREG_W(5)) dut (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
        .D_is_branch(D_is_branch), .D_is_jr(D_is_jr), .D_wa(D_wa), .D_tnew(D_tnew),
        .cmp_eq(cmp_eq), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .redirect(redirect), .E_wa_o(E_wa_o)
`ifdef BRANCH_STATS_EN
        , .stat_stall_cycles(stat_stall_cycles), .stat_taken(stat_taken)
`endif
    );

    typedef struct {
        bit          chk;
        bit          stall;
        int          rs_sel;
        int          rt_sel;
        bit          redir;
        int          ewa;
        int unsigned sc;
        int unsigned tk;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Model: the last three instructions that left D (index 0 = youngest, in E).
    // A bubble is recorded as writing register 0.
    int hwa[3];
    int ht[3];
    int unsigned m_sc, m_tk;

    function automatic int remaining(int k);
        if (k == 2) return 0;               // W results are always available
        return (ht[k] > k) ? ht[k] - k : 0;
    endfunction

    function automatic int source(int r);
        if (r == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (hwa[k] == r && remaining(k) == 0) return k + 1;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: compares one expectation per cycle, mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    check("stall", int'(stall), int'(e.stall));
                    check("fwd_rs_sel", int'(fwd_rs_sel), e.rs_sel);
                    check("fwd_rt_sel", int'(fwd_rt_sel), e.rt_sel);
                    check("redirect", int'(redirect), int'(e.redir));
                    check("E_wa_o", int'(E_wa_o), e.ewa);
`ifdef BRANCH_STATS_EN
                    check("stat_stall_cycles", int'(stat_stall_cycles), int'(e.sc));
                    check("stat_taken", int'(stat_taken), int'(e.tk));
`endif
                end
            end
        end
    end

    // Drive one cycle, push its expected response, then advance the model at the clock
    task automatic step(input bit rst, input bit v, input int rs, input int rt,
                        input bit br, input bit jr, input int wa, input int tn,
                        input bit eq, input bit chk);
        exp_t e;
        bit   rs_used, rt_used, st;
        reset = rst; D_valid = v; D_rs = 5'(rs); D_rt = 5'(rt);
        D_is_branch = br; D_is_jr = jr; D_wa = 5'(wa); D_tnew = 2'(tn); cmp_eq = eq;
        rs_used = v && (br || jr);
        rt_used = v && br;
        st = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (hwa[k] != 0 && remaining(k) > 0) begin
                if (rs_used && hwa[k] == rs) st = 1'b1;
                if (rt_used && hwa[k] == rt) st = 1'b1;
            end
        end
        e.chk = chk; e.stall = st; e.rs_sel = source(rs); e.rt_sel = source(rt);
        e.redir = v && br && eq && !st; e.ewa = hwa[0]; e.sc = m_sc; e.tk = m_tk;
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin hwa[k] = 0; ht[k] = 0; end
            m_sc = 0; m_tk = 0;
        end else begin
            m_sc += st ? 1 : 0;
            m_tk += e.redir ? 1 : 0;
            hwa[2] = hwa[1]; ht[2] = ht[1];
            hwa[1] = hwa[0]; ht[1] = ht[0];
            hwa[0] = (st || !v) ? 0 : wa;
            ht[0]  = (st || !v) ? 0 : tn;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin hwa[k] = 0; ht[k] = 0; end
        m_sc = 0; m_tk = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // DUT state unknown before first clock
        step(1, 1, 8, 8, 1, 0, 0, 0, 1, 1);   // reset state visible, no stall
        idle(1);

        // Load-use on branch: lw $8, then beq $8,$9 held through the stall
        step(0, 1, 0, 0, 0, 0, 8, 2, 0, 1);
        repeat (3) step(0, 1, 8, 9, 1, 0, 0, 0, 1, 1);
        idle(3);

        // ALU-to-branch: addu $3, then beq $3,$3 taken
        step(0, 1, 1, 2, 0, 0, 3, 1, 0, 1);
        repeat (2) step(0, 1, 3, 3, 1, 0, 0, 0, 1, 1);
        idle(3);

        // Tnew=0 producer: jal writes $31, then jr $31
        step(0, 1, 0, 0, 0, 0, 31, 0, 0, 1);
        step(0, 1, 31, 0, 0, 1, 0, 0, 1, 1);
        idle(3);

        // $0 immunity: lw $0, then beq $0,$0 both ways
        step(0, 1, 0, 0, 0, 0, 0, 2, 0, 1);
        step(0, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        idle(3);

        // Priority: addu $5, lui $5, beq $5,$0
        step(0, 1, 1, 2, 0, 0, 5, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 5, 0, 0, 1);
        step(0, 1, 5, 0, 1, 0, 0, 0, 1, 1);
        idle(3);

        // Reset during a load-use stall
        step(0, 1, 0, 0, 0, 0, 8, 2, 0, 1);
        step(0, 1, 8, 9, 1, 0, 0, 0, 1, 1);
        step(1, 1, 8, 9, 1, 0, 0, 0, 1, 1);
        step(0, 1, 8, 9, 1, 0, 0, 0, 1, 1);
        idle(2);

        // Random traffic over a small register set to force collisions
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 9) != 0),
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom_range(0, 1), 1);
        end
        idle(1);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
